// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline widths and data-memory defaults for the MEM/WB slice.
package mem_wb_stage_pkg;

  localparam int XLEN          = 32;   // datapath width
  localparam int REG_ADDR_W    = 5;    // register-file index width
  localparam int DEFAULT_DEPTH = 256;  // data memory words

endpackage

// File: rtl/mem_wb_stage_dmem_ram.sv
// Word-wide data memory: combinational read port, clocked write port.
// Contents are deliberately left uninitialised and are never reset.
module dmem_ram
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_q [DEPTH];

  // Commit a store on the rising edge; a same-cycle read still sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: address checking, data memory access, result selection and
// the MEM/WB pipeline register feeding register-file write-back.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  clrn,
  input  logic                  mem_wmem,
  input  logic                  mem_m2reg,
  input  logic                  mem_wreg,
  input  logic [REG_ADDR_W-1:0] mem_rn,
  input  logic [XLEN-1:0]       mem_Alu_Result,
  input  logic [XLEN-1:0]       mem_rb,
  input  logic                  hold,
  output logic [XLEN-1:0]       mem_fwd_data,
  output logic                  mem_addr_err,
  output logic                  wb_wreg,
  output logic [REG_ADDR_W-1:0] wb_rn,
  output logic [XLEN-1:0]       wb_data,
  output logic                  wb_addr_err
);

  logic            is_access;
  logic            addr_bad;
  logic            ram_we;
  logic [AW-1:0]   word_idx;
  logic [XLEN-1:0] ram_rdata;
  logic [XLEN-1:0] load_data;

  logic                  wb_wreg_q, wb_wreg_d;
  logic [REG_ADDR_W-1:0] wb_rn_q, wb_rn_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;
  logic                  wb_addr_err_q, wb_addr_err_d;

  assign word_idx = mem_Alu_Result[AW+1:2];

  // Classify the access: misaligned or beyond the array is bad; only loads
  // and stores can raise an error.
  always_comb begin
    is_access    = mem_wmem | mem_m2reg;
    addr_bad     = (|mem_Alu_Result[1:0]) | (|mem_Alu_Result[XLEN-1:AW+2]);
    mem_addr_err = is_access & addr_bad;
    ram_we       = mem_wmem & ~addr_bad;
  end

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_idx),
    .wdata (mem_rb),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  // Bad loads read as zero so a faulting instruction carries no stale data.
  always_comb begin
    load_data    = addr_bad ? '0 : ram_rdata;
    mem_fwd_data = mem_m2reg ? load_data : mem_Alu_Result;
  end

  // Next MEM/WB contents: freeze on hold, otherwise capture this stage's result.
  always_comb begin
    wb_wreg_d     = wb_wreg_q;
    wb_rn_d       = wb_rn_q;
    wb_data_d     = wb_data_q;
    wb_addr_err_d = wb_addr_err_q;
    if (!hold) begin
      wb_wreg_d     = mem_wreg & ~mem_addr_err;
      wb_rn_d       = mem_rn;
      wb_data_d     = mem_fwd_data;
      wb_addr_err_d = mem_addr_err;
    end
  end

  // MEM/WB pipeline register; asynchronous reset overrides hold.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wb_wreg_q     <= 1'b0;
      wb_rn_q       <= '0;
      wb_data_q     <= '0;
      wb_addr_err_q <= 1'b0;
    end else begin
      wb_wreg_q     <= wb_wreg_d;
      wb_rn_q       <= wb_rn_d;
      wb_data_q     <= wb_data_d;
      wb_addr_err_q <= wb_addr_err_d;
    end
  end

  assign wb_wreg     = wb_wreg_q;
  assign wb_rn       = wb_rn_q;
  assign wb_data     = wb_data_q;
  assign wb_addr_err = wb_addr_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed test-plan steps followed by
// randomized traffic, compared against a word-array reference model.
module tb_mem_wb_stage;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mem_wmem, mem_m2reg, mem_wreg, hold;
  logic [4:0]  mem_rn;
  logic [31:0] mem_Alu_Result, mem_rb;
  logic [31:0] mem_fwd_data;
  logic        mem_addr_err;
  logic        wb_wreg;
  logic [4:0]  wb_rn;
  logic [31:0] wb_data;
  logic        wb_addr_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  logic        ref_wreg;
  logic [4:0]  ref_rn;
  logic [31:0] ref_data;
  logic        ref_err;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .clrn           (clrn),
    .mem_wmem       (mem_wmem),
    .mem_m2reg      (mem_m2reg),
    .mem_wreg       (mem_wreg),
    .mem_rn         (mem_rn),
    .mem_Alu_Result (mem_Alu_Result),
    .mem_rb         (mem_rb),
    .hold           (hold),
    .mem_fwd_data   (mem_fwd_data),
    .mem_addr_err   (mem_addr_err),
    .wb_wreg        (wb_wreg),
    .wb_rn          (wb_rn),
    .wb_data        (wb_data),
    .wb_addr_err    (wb_addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, "_wreg"}, {31'd0, wb_wreg}, {31'd0, ref_wreg});
    chk({tag, "_rn"}, {27'd0, wb_rn}, {27'd0, ref_rn});
    chk({tag, "_data"}, wb_data, ref_data);
    chk({tag, "_err"}, {31'd0, wb_addr_err}, {31'd0, ref_err});
  endtask

  // One instruction: called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic w, input logic m, input logic r, input logic [4:0] rn,
                      input logic [31:0] a, input logic [31:0] b, input logic h);
    logic        bad, err;
    logic [31:0] ld, fwd;
    int unsigned idx;
    mem_wmem = w; mem_m2reg = m; mem_wreg = r; mem_rn = rn;
    mem_Alu_Result = a; mem_rb = b; hold = h;
    bad = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
    err = (w || m) && bad;
    idx = a / 4;
    ld  = bad ? 32'h0 : ref_mem[idx];
    fwd = m ? ld : a;
    #4;
    chk("comb_err", {31'd0, mem_addr_err}, {31'd0, err});
    chk("comb_fwd", mem_fwd_data, fwd);
    @(posedge clk);
    if (w && !bad) ref_mem[idx] = b;
    if (!h) begin
      ref_wreg = r && !err;
      ref_rn   = rn;
      ref_data = fwd;
      ref_err  = err;
    end
    #1;
    chk_wb("wb");
    $display("step w=%0b m=%0b r=%0b rn=%0d a=%h b=%h h=%0b -> fwd=%h err=%0b wb=%0b/%0d/%h/%0b",
             w, m, r, rn, a, b, h, mem_fwd_data, mem_addr_err, wb_wreg, wb_rn, wb_data, wb_addr_err);
  endtask

  initial begin
    logic [31:0] a, b;
    int unsigned kind, sel;

    // Reset with random register-side inputs
    clrn = 1'b0; hold = 1'b0; mem_wmem = 1'b0;
    ref_wreg = 1'b0; ref_rn = '0; ref_data = '0; ref_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_m2reg = 1'($urandom); mem_wreg = 1'($urandom); mem_rn = 5'($urandom);
      mem_Alu_Result = $urandom; mem_rb = $urandom; hold = 1'($urandom);
      @(posedge clk); #1;
      chk_wb("reset");
    end
    clrn = 1'b1;

    // Give every word a defined value
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 32'(i * 4), $urandom, 1'b0);

    // Store then load
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5'd5, 32'h10, 32'h0, 1'b0);
    chk("ld10_data", wb_data, 32'hDEADBEEF);
    chk("ld10_rn", {27'd0, wb_rn}, 32'd5);
    chk("ld10_wreg", {31'd0, wb_wreg}, 32'd1);

    // ALU pass-through with a misaligned-looking value
    step(1'b0, 1'b0, 1'b1, 5'd7, 32'h3, 32'h0, 1'b0);
    chk("alu_data", wb_data, 32'h3);
    chk("alu_err", {31'd0, wb_addr_err}, 32'd0);

    // Misaligned store must not disturb the word at 0x20
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'h22222222, 1'b0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h22, 32'h11111111, 1'b0);
    chk("mis_st_err", {31'd0, wb_addr_err}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 5'd3, 32'h20, 32'h0, 1'b0);
    chk("mis_st_keep", wb_data, 32'h22222222);
    step(1'b0, 1'b1, 1'b1, 5'd3, 32'h22, 32'h0, 1'b0);
    chk("mis_ld_wreg", {31'd0, wb_wreg}, 32'd0);
    chk("mis_ld_err", {31'd0, wb_addr_err}, 32'd1);
    chk("mis_ld_data", wb_data, 32'h0);

    // Out of range and the last word
    step(1'b0, 1'b1, 1'b1, 5'd4, 32'h400, 32'h0, 1'b0);
    chk("oor_wreg", {31'd0, wb_wreg}, 32'd0);
    chk("oor_data", wb_data, 32'h0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h3FC, 32'hCAFEF00D, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5'd6, 32'h3FC, 32'h0, 1'b0);
    chk("last_word", wb_data, 32'hCAFEF00D);

    // Same-cycle store+load sees old data, next load sees new
    step(1'b1, 1'b1, 1'b1, 5'd8, 32'h10, 32'h12345678, 1'b0);
    chk("rw_old", wb_data, 32'hDEADBEEF);
    step(1'b0, 1'b1, 1'b1, 5'd8, 32'h10, 32'h0, 1'b0);
    chk("rw_new", wb_data, 32'h12345678);

    // Hold freezes wb_*, release captures current inputs
    step(1'b0, 1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'($urandom), 5'($urandom), $urandom, 32'h0, 1'b1);
      chk("hold_data", wb_data, 32'hA5A5A5A5);
    end
    step(1'b0, 1'b0, 1'b1, 5'd11, 32'h0BADC0DE, 32'h0, 1'b0);
    chk("release", wb_data, 32'h0BADC0DE);

    // Asynchronous reset pulse while holding
    mem_wmem = 1'b0; hold = 1'b1;
    #2 clrn = 1'b0;
    #1;
    ref_wreg = 1'b0; ref_rn = '0; ref_data = '0; ref_err = 1'b0;
    chk_wb("async_rst");
    #1 clrn = 1'b1;
    @(posedge clk); #1;
    chk_wb("post_rst");

    // Memory survives reset
    step(1'b0, 1'b1, 1'b1, 5'd2, 32'h3FC, 32'h0, 1'b0);
    chk("mem_kept", wb_data, 32'hCAFEF00D);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (sel == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
      else               a = $urandom;
      b = $urandom;
      kind = $urandom_range(0, 3);
      step(kind == 0 || kind == 3, kind == 1 || kind == 3, 1'($urandom), 5'($urandom),
           a, b, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage of the 5-stage pipelined CPU, directly downstream of the EXE/MEM pipeline register.
- Contains the word-addressed data memory, address checking, and result selection (ALU result vs. load data).
- Registers the selected result into the MEM/WB pipeline register that feeds register-file write-back.
- Exposes a combinational MEM-stage result for forwarding to EXE.

Parameters:
DEPTH, 256, number of 32-bit words in data memory (power of two, 2..65536)
AW, 8, word-index width = log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
clrn  input  1  asynchronous active-low reset
mem_wmem  input  1  store enable from EXE/MEM register
mem_m2reg  input  1  result source: 1 = load data, 0 = ALU result
mem_wreg  input  1  register-file write enable
mem_rn  input  5  destination register number
mem_Alu_Result  input  32  byte address, or ALU result
mem_rb  input  32  store data
hold  input  1  freeze MEM/WB register (downstream stall)
mem_fwd_data  output  32  combinational MEM-stage result for forwarding
mem_addr_err  output  1  combinational: current access misaligned or out of range
wb_wreg  output  1  registered write enable
wb_rn  output  5  registered destination
wb_data  output  32  registered write-back value
wb_addr_err  output  1  registered address error (sticky until next instruction)

Behaviour:
- Access validity:
  - An access is an access when mem_wmem=1 or mem_m2reg=1.
  - The access is bad if mem_Alu_Result[1:0]!=0 or mem_Alu_Result[31:AW+2]!=0.
  - mem_addr_err = access && bad. It is 0 for non-memory instructions, whatever the address.
- Word index: mem_Alu_Result[AW+1:2].
- Read: asynchronous and combinational from the array. A bad load returns 32'h0.
- Write:
  - At posedge clk when mem_wmem=1 and the access is not bad, mem[index] <= mem_rb.
  - A bad store writes nothing.
  - Writes are not gated by hold; a repeated identical store during a stall is idempotent.
- Same-cycle read/write: the load in the same cycle sees old contents. A load in the next cycle sees the new word.
- Result selection: mem_fwd_data = mem_m2reg ? load_data : mem_Alu_Result.
- MEM/WB register, posedge clk:
  - hold=1: all wb_* keep their values.
  - hold=0: wb_rn <= mem_rn, wb_data <= mem_fwd_data, wb_addr_err <= mem_addr_err, and wb_wreg <= mem_wreg && !mem_addr_err (a faulting load never writes the register file).
- Latency: one cycle from the MEM inputs to the wb_* outputs.
- Reset (clrn=0, asynchronous):
  - wb_wreg=0, wb_rn=0, wb_data=0, wb_addr_err=0.
  - Memory contents are NOT cleared; they are undefined until written.
  - A reset asserted mid-cycle discards the in-flight instruction; any store already committed at an earlier edge remains.
- Reset has priority over hold.
- Combinational outputs follow the inputs during reset. Upstream registers are also zeroed, so mem_addr_err=0 during reset.

Decomposition:
- Shared package/header: pipeline field widths (REG_ADDR_W=5, XLEN=32) and the default DEPTH constant.
- One sub-module, dmem_ram: DEPTH x 32 array with async read and sync write.
- mem_wb_stage instantiates dmem_ram and holds the address checking, result mux and MEM/WB register.

Test Plan:
- Reset: hold clrn=0 with random inputs -> wb_wreg=0, wb_rn=0, wb_data=0, wb_addr_err=0.
- Store/load: store 32'hDEADBEEF at addr 0x10, then load from 0x10 with mem_wreg=1, mem_rn=5 next cycle -> mem_fwd_data=32'hDEADBEEF in that cycle; one cycle later wb_data=32'hDEADBEEF, wb_rn=5, wb_wreg=1.
- ALU pass-through: mem_m2reg=0, mem_wmem=0, mem_Alu_Result=32'h00000003, mem_wreg=1, mem_rn=7 -> mem_addr_err=0 (no access); next cycle wb_data=3, wb_rn=7, wb_wreg=1.
- Misaligned store: store 32'h11111111 to 0x22 -> mem_addr_err=1, no write; load from 0x20 -> prior contents unchanged. Misaligned load from 0x22 with mem_wreg=1 -> wb_wreg=0, wb_addr_err=1, wb_data=0.
- Out of range with DEPTH=256: load from 0x400 -> mem_addr_err=1, wb_wreg=0, wb_data=0. Store to 0x3FC, then load from 0x3FC -> stored value returned.
- Hold: set wb_data=32'hA5A5A5A5, then assert hold for 3 cycles while inputs change -> wb_* unchanged. Release hold -> next edge captures the current inputs. Pulse clrn low during hold -> wb_* go to 0 immediately.
